mul_div_unit: RTL and testbench

Parametrised multicycle multiply/divide unit producing HI/LO results for the multicycle MIPS core; successor to the fixed 32-bit shift-add multiplier. Supports signed/unsigned multiply and divide (MULT, MULTU, DIV, DIVU), direct HI/LO writes (MTHI/MTLO), and a Start/Busy/Done handshake driven by the controller FSM. Sits beside the ULA, fed from registers A and B, with Hi/Lo read through the register-write mux.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_step.sv | 40 ++++
 rtl/mul_div_unit.sv | 152 +++++++++++++++
 tb/tb_mul_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multicycle multiply/divide unit.
// Operation encoding matches the controller's Op field; state encoding is exposed for debug.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring divide.
// The divide branch exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             isDiv,
`endif
  input  logic [WIDTH-1:0] accHi,
  input  logic [WIDTH-1:0] accLo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nextHi,
  output logic [WIDTH-1:0] nextLo
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;
`endif

  always_comb begin
    // Multiply: accLo holds the remaining multiplier bits, product grows in from the top.
    sum    = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    nextHi = sum[WIDTH:1];
    nextLo = {sum[0], accLo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    shifted = {accHi, accLo[WIDTH-1]};
    fits    = shifted >= {1'b0, operand};
    // Remainder stays below the divisor, so the trial difference fits in WIDTH bits.
    diff    = shifted[WIDTH-1:0] - operand;
    if (isDiv) begin
      nextHi = fits ? diff : shifted[WIDTH-1:0];
      nextLo = {accLo[WIDTH-2:0], fits};
    end
`endif
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multicycle signed/unsigned multiply/divide unit with HI/LO registers for the MIPS core.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  muldiv_op_t    Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic          WriteHi,
  input  logic          WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic          Busy,
  output logic          Done,
  output logic          DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output muldiv_state_t DebugState
);

  // Handshake: Start is taken only while Busy is low; Busy stays high until the
  // cycle Done pulses, and Hi/Lo are valid from that Done cycle onward.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  muldiv_state_t state, nextState;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] accHi, accLo, operandReg;
  logic [WIDTH-1:0] stepHi, stepLo;
  logic             signA, signB, skipFix;
  logic             signedOp, skipStart;
  logic [WIDTH-1:0] absA, absB;
  logic [2*WIDTH-1:0] product;
`ifdef MULDIV_DIV_EN
  logic             opIsDiv;
  logic [WIDTH-1:0] quotient, remainder;
`endif

  assign signedOp = ~Op[0];
  assign absA = (signedOp && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign absB = (signedOp && OperandB[WIDTH-1]) ? -OperandB : OperandB;
`ifdef MULDIV_DIV_EN
  assign skipStart = Op[1] && (OperandB == '0);
`else
  assign skipStart = Op[1];
`endif

  assign Busy       = (state != IDLE);
  assign DebugState = state;

  muldiv_step #(.WIDTH(WIDTH)) step (
`ifdef MULDIV_DIV_EN
    .isDiv   (opIsDiv),
`endif
    .accHi   (accHi),
    .accLo   (accLo),
    .operand (operandReg),
    .nextHi  (stepHi),
    .nextLo  (stepLo)
  );

  always_comb begin
    product = (signA ^ signB) ? -{accHi, accLo} : {accHi, accLo};
`ifdef MULDIV_DIV_EN
    // Truncating division: quotient sign from both operands, remainder follows the dividend.
    quotient  = (signA ^ signB) ? -accLo : accLo;
    remainder = signA ? -accHi : accHi;
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start) nextState = skipStart ? FIX : CALC;
      CALC:    if (count == LastCount) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count      <= '0;
      accHi      <= '0;
      accLo      <= '0;
      operandReg <= '0;
      signA      <= 1'b0;
      signB      <= 1'b0;
      skipFix    <= 1'b0;
`ifdef MULDIV_DIV_EN
      opIsDiv    <= 1'b0;
`endif
      Done       <= 1'b0;
      DivZero    <= 1'b0;
      Hi         <= '0;
      Lo         <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (WriteHi) Hi <= WriteData;
          if (WriteLo) Lo <= WriteData;
          if (Start) begin
            accHi      <= '0;
            accLo      <= absA;
            operandReg <= absB;
            signA      <= signedOp & OperandA[WIDTH-1];
            signB      <= signedOp & OperandB[WIDTH-1];
            skipFix    <= skipStart;
            count      <= '0;
`ifdef MULDIV_DIV_EN
            opIsDiv    <= Op[1];
`endif
          end
        end
        CALC: begin
          accHi <= stepHi;
          accLo <= stepLo;
          count <= count + 1'b1;
        end
        FIX: begin
          Done <= 1'b1;
`ifdef MULDIV_DIV_EN
          if (skipFix) begin
            DivZero <= 1'b1;
          end else if (opIsDiv) begin
            Hi <= remainder;
            Lo <= quotient;
          end else begin
            {Hi, Lo} <= product;
          end
`else
          if (!skipFix) {Hi, Lo} <= product;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (WIDTH=32); divide expectations follow MULDIV_DIV_EN.
module tb_mul_div_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          WriteHi = 1'b0;
  logic          WriteLo = 1'b0;
  muldiv_op_t    Op = MULTU;
  logic [W-1:0]  OperandA = '0;
  logic [W-1:0]  OperandB = '0;
  logic [W-1:0]  WriteData = '0;
  logic          Busy, Done, DivZero;
  logic [W-1:0]  Hi, Lo;
  muldiv_state_t DebugState;

  int checks = 0;
  int failures = 0;
  int edges;
  int doneCount;

  mul_div_unit #(.WIDTH(W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .WriteHi    (WriteHi),
    .WriteLo    (WriteLo),
    .WriteData  (WriteData),
    .Busy       (Busy),
    .Done       (Done),
    .DivZero    (DivZero),
    .Hi         (Hi),
    .Lo         (Lo),
    .DebugState (DebugState)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the Start edge.
  task automatic startOp(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    Op = op;
    OperandA = a;
    OperandB = b;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic waitDone(input int from, output int n);
    n = from;
    while (Done !== 1'b1 && n < 200) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic idleCount(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge Clock);
      if (Done === 1'b1) cnt++;
    end
  endtask

  task automatic writeHiLo(input logic hiEn, input logic loEn, input logic [W-1:0] data);
    WriteHi = hiEn;
    WriteLo = loEn;
    WriteData = data;
    @(negedge Clock);
    WriteHi = 1'b0;
    WriteLo = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    check("reset_divzero", DivZero, 1'b0);
    check("reset_hi", Hi, 32'h0);
    check("reset_lo", Lo, 32'h0);
    check("reset_state", DebugState, IDLE);

    startOp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", Busy, 1'b1);
    check("multu_state_calc", DebugState, CALC);
    check("multu_hold_lo", Lo, 32'h0);
    waitDone(0, edges);
    check("multu_latency", edges, 33);
    check("multu_hi", Hi, 32'hFFFF_FFFE);
    check("multu_lo", Lo, 32'h0000_0001);
    check("multu_busy_low_at_done", Busy, 1'b0);
    check("multu_divzero", DivZero, 1'b0);
    @(negedge Clock);
    check("multu_done_one_cycle", Done, 1'b0);

    startOp(MULT, 32'hFFFF_FFFD, 32'd7);
    waitDone(0, edges);
    check("mult_neg_pos_hi", Hi, 32'hFFFF_FFFF);
    check("mult_neg_pos_lo", Lo, 32'hFFFF_FFEB);

    startOp(MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFC);
    waitDone(0, edges);
    check("mult_neg_neg_hi", Hi, 32'h0);
    check("mult_neg_neg_lo", Lo, 32'd20);

    @(negedge Clock);
    writeHiLo(1'b1, 1'b0, 32'h0000_1234);
    check("writehi_hi", Hi, 32'h0000_1234);
    check("writehi_lo_kept", Lo, 32'd20);

`ifdef MULDIV_DIV_EN
    startOp(DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone(0, edges);
    check("div_latency", edges, 33);
    check("div_neg_lo", Lo, 32'hFFFF_FFFD);
    check("div_neg_hi", Hi, 32'hFFFF_FFFF);

    startOp(DIVU, 32'd100, 32'd7);
    waitDone(0, edges);
    check("divu_lo", Lo, 32'd14);
    check("divu_hi", Hi, 32'd2);

    startOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(0, edges);
    check("div_min_lo", Lo, 32'h8000_0000);
    check("div_min_hi", Hi, 32'h0);

    @(negedge Clock);
    writeHiLo(1'b1, 1'b1, 32'h55);
    startOp(DIVU, 32'd100, 32'd0);
    waitDone(0, edges);
    check("divzero_latency", edges, 1);
    check("divzero_flag", DivZero, 1'b1);
    check("divzero_hi_kept", Hi, 32'h55);
    check("divzero_lo_kept", Lo, 32'h55);
    @(negedge Clock);
    check("divzero_flag_one_cycle", DivZero, 1'b0);
`else
    @(negedge Clock);
    writeHiLo(1'b1, 1'b1, 32'h55);
    startOp(DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone(0, edges);
    check("nodiv_latency", edges, 1);
    check("nodiv_divzero", DivZero, 1'b0);
    check("nodiv_hi_kept", Hi, 32'h55);
    check("nodiv_lo_kept", Lo, 32'h55);
`endif

    @(negedge Clock);
    startOp(MULTU, 32'd3, 32'd5);
    repeat (5) @(negedge Clock);
    startOp(MULTU, 32'd2, 32'd2);
    waitDone(6, edges);
    check("busy_start_latency", edges, 33);
    check("busy_start_lo", Lo, 32'd15);
    idleCount(40, doneCount);
    check("busy_start_single_done", doneCount, 0);

    startOp(MULTU, 32'd6, 32'd7);
    waitDone(0, edges);
    check("chain_first_lo", Lo, 32'd42);
    startOp(MULTU, 32'h0001_0000, 32'h0001_0000);
    check("chain_accepted_busy", Busy, 1'b1);
    waitDone(0, edges);
    check("chain_latency", edges, 33);
    check("chain_hi", Hi, 32'h1);
    check("chain_lo", Lo, 32'h0);

    @(negedge Clock);
    startOp(MULTU, 32'd9, 32'd9);
    writeHiLo(1'b0, 1'b1, 32'hDEAD);
    check("busy_writelo_ignored", Lo, 32'h0);
    check("busy_hi_held", Hi, 32'h1);
    waitDone(1, edges);
    check("busy_writelo_latency", edges, 33);
    check("busy_writelo_result_lo", Lo, 32'd81);
    check("busy_writelo_result_hi", Hi, 32'h0);

    @(negedge Clock);
    startOp(MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (10) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("midreset_busy", Busy, 1'b0);
    check("midreset_hi", Hi, 32'h0);
    check("midreset_lo", Lo, 32'h0);
    check("midreset_state", DebugState, IDLE);
    @(negedge Clock);
    Reset = 1'b0;
    idleCount(40, doneCount);
    check("midreset_no_done", doneCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
